// File: rtl/hook_launch_controller.sv
// Hook launch controller: debounces the launch key into a single launch pulse
// (only when the hook is at home), detects hook/object overlap while extending
// and issues one reverse pulse per extension, and supervises extend/retract
// durations with a forced return and a sticky retract watchdog.
module hook_launch_controller #(
    parameter int HOME_X             = 280,
    parameter int HOME_Y             = 185,
    parameter int DEBOUNCE_FRAMES    = 2,
    parameter int MAX_EXTEND_FRAMES  = 90,
    parameter int MAX_RETRACT_FRAMES = 180
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               key_launch,
    input  logic signed [10:0] hookTopLeftX,
    input  logic signed [10:0] hookTopLeftY,
    input  logic               drawingRequest_hook,
    input  logic               drawingRequest_object,
    output logic               launch_Cable,
    output logic               collision,
    output logic               hook_busy,
    output logic [7:0]         grab_count,
    output logic               watchdog_flag
);

    localparam logic signed [10:0] HOME_X_C = HOME_X[10:0];
    localparam logic signed [10:0] HOME_Y_C = HOME_Y[10:0];
    localparam logic [7:0]         DEB_C    = DEBOUNCE_FRAMES[7:0];
    localparam logic [7:0]         MAXE_C   = MAX_EXTEND_FRAMES[7:0];
    localparam logic [7:0]         MAXR_C   = MAX_RETRACT_FRAMES[7:0];

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_EXTENDING  = 2'd1,
        ST_RETRACTING = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] deb_cnt_r, deb_cnt_s;
    logic       press_armed_r, press_armed_s;
    logic       hit_flag_r, hit_flag_s;
    logic [7:0] frame_cnt_r, frame_cnt_s;
    logic       launch_r, launch_s;
    logic       collision_r, collision_s;
    logic       hook_busy_r, hook_busy_s;
    logic [7:0] grab_count_r, grab_count_s;
    logic       watchdog_r, watchdog_s;
    logic       press_accept_s;
    logic       at_home_s;
    logic       overlap_s;

    assign at_home_s = (hookTopLeftX == HOME_X_C) && (hookTopLeftY == HOME_Y_C);
    assign overlap_s = drawingRequest_hook && drawingRequest_object;

    assign launch_Cable  = launch_r;
    assign collision     = collision_r;
    assign hook_busy     = hook_busy_r;
    assign grab_count    = grab_count_r;
    assign watchdog_flag = watchdog_r;

    // Next-state, debounce, counters and pulse generation.
    always_comb begin
        state_s        = state_r;
        deb_cnt_s      = deb_cnt_r;
        press_armed_s  = press_armed_r;
        hit_flag_s     = hit_flag_r;
        frame_cnt_s    = frame_cnt_r;
        launch_s       = 1'b0;
        collision_s    = 1'b0;
        hook_busy_s    = (state_r != ST_IDLE);
        grab_count_s   = grab_count_r;
        watchdog_s     = watchdog_r;
        press_accept_s = 1'b0;

        // Debounce runs in every state so release is always tracked; a press
        // accepted outside IDLE is simply consumed.
        if (startOfFrame) begin
            if (key_launch) begin
                if (deb_cnt_r < DEB_C) begin
                    deb_cnt_s = deb_cnt_r + 8'd1;
                    if (press_armed_r && ((deb_cnt_r + 8'd1) == DEB_C)) begin
                        press_accept_s = 1'b1;
                        press_armed_s  = 1'b0;
                    end else begin
                        press_accept_s = 1'b0;
                    end
                end else begin
                    deb_cnt_s = deb_cnt_r;
                end
            end else begin
                deb_cnt_s     = 8'd0;
                press_armed_s = 1'b1;
            end
        end else begin
            deb_cnt_s = deb_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                hit_flag_s  = 1'b0;
                frame_cnt_s = 8'd0;
                if (press_accept_s && at_home_s) begin
                    launch_s = 1'b1;
                    state_s  = ST_EXTENDING;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXTENDING: begin
                if (startOfFrame) begin
                    if (hit_flag_r) begin
                        // A hit wins over a simultaneous timeout.
                        collision_s = 1'b1;
                        if (grab_count_r != 8'd255) begin
                            grab_count_s = grab_count_r + 8'd1;
                        end else begin
                            grab_count_s = grab_count_r;
                        end
                        hit_flag_s  = 1'b0;
                        frame_cnt_s = 8'd0;
                        state_s     = ST_RETRACTING;
                    end else if (frame_cnt_r == (MAXE_C - 8'd1)) begin
                        collision_s = 1'b1;
                        hit_flag_s  = 1'b0;
                        frame_cnt_s = 8'd0;
                        state_s     = ST_RETRACTING;
                    end else begin
                        frame_cnt_s = frame_cnt_r + 8'd1;
                        hit_flag_s  = overlap_s;
                    end
                end else begin
                    hit_flag_s = hit_flag_r | overlap_s;
                end
            end
            ST_RETRACTING: begin
                hit_flag_s = 1'b0;
                if (at_home_s) begin
                    frame_cnt_s = 8'd0;
                    state_s     = ST_IDLE;
                end else if (startOfFrame) begin
                    if (frame_cnt_r == (MAXR_C - 8'd1)) begin
                        watchdog_s  = 1'b1;
                        frame_cnt_s = 8'd0;
                        state_s     = ST_IDLE;
                    end else begin
                        frame_cnt_s = frame_cnt_r + 8'd1;
                    end
                end else begin
                    frame_cnt_s = frame_cnt_r;
                end
            end
            default: begin
                hit_flag_s  = 1'b0;
                frame_cnt_s = 8'd0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops; reset aborts everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            deb_cnt_r     <= 8'd0;
            press_armed_r <= 1'b0;
            hit_flag_r    <= 1'b0;
            frame_cnt_r   <= 8'd0;
            launch_r      <= 1'b0;
            collision_r   <= 1'b0;
            hook_busy_r   <= 1'b0;
            grab_count_r  <= 8'd0;
            watchdog_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            deb_cnt_r     <= deb_cnt_s;
            press_armed_r <= press_armed_s;
            hit_flag_r    <= hit_flag_s;
            frame_cnt_r   <= frame_cnt_s;
            launch_r      <= launch_s;
            collision_r   <= collision_s;
            hook_busy_r   <= hook_busy_s;
            grab_count_r  <= grab_count_s;
            watchdog_r    <= watchdog_s;
        end
    end

endmodule
